// File: rtl/seg_display_scan.sv
// ---------------------------------------------------------------------------
// seg_display_scan
//
// Shows a 14-bit binary credit/price value on the BASYS3 four-digit,
// common-anode 7-segment display. The value is converted to four BCD digits
// by a sequential double-dabble engine. The digits are then time-multiplexed,
// advancing one digit per rising edge of the ~1 kHz divided clock. Leading
// zeros can be blanked, and a fixed decimal point gives dollars.cents.
//
// Ports:
//   Clk    in   1   100 MHz system clock (the only clock)
//   Rst    in   1   synchronous, active-high reset
//   ClkIn  in   1   divided ~1 kHz square wave, sampled as data
//   Value  in  14   binary value to show; values above 9999 saturate
//   Seg    out  7   cathodes {g,f,e,d,c,b,a}, active-low, registered
//   Dp     out  1   decimal-point cathode, active-low, registered
//   An     out  4   anodes, active-low, An[0] = ones digit, registered
//   Busy   out  1   high while a BCD conversion is in progress
//
// Parameters:
//   BLANK_LZ  1 = blank leading zero digits above the decimal-point digit
//   DP_POS    digit whose decimal point is lit (0..3), 4 = none
// ---------------------------------------------------------------------------
module seg_display_scan #(
  parameter bit BLANK_LZ = 1'b1,
  parameter int DP_POS   = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ClkIn,
  input  logic [13:0] Value,
  output logic [6:0]  Seg,
  output logic        Dp,
  output logic [3:0]  An,
  output logic        Busy
);

  // Three bits, so that DP_POS = 4 can never match a 2-bit digit index.
  localparam logic [2:0] DP_SEL = 3'(DP_POS);

  // Digits at or below this index are never blanked. Without a decimal
  // point, only the ones digit is kept.
  localparam logic [1:0] BLANK_MIN = (DP_POS < 4) ? 2'(DP_POS) : 2'd0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        clkin_q;
  logic        tick;
  logic [1:0]  idx;

  logic [13:0] vsat;
  logic [13:0] last;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic [15:0] bcd_adj;
  logic [3:0]  count;
  logic [15:0] disp;

  logic        load;
  logic        shift_en;
  logic        write_disp;

  logic [3:0]  digit;
  logic        upper_zero;
  logic        blank;
  logic [6:0]  seg_dec;

  // One-cycle pulse on each rising edge of the divided clock.
  // A level held high produces exactly one pulse.
  assign tick = ClkIn & ~clkin_q;

  // Anything above four digits is shown as 9999.
  assign vsat = (Value > 14'd9999) ? 14'd9999 : Value;

  // Double-dabble correction: any BCD nibble of 5 or more gets 3 added.
  // The following left shift then carries it correctly into the next decade.
  always_comb begin
    bcd_adj = bcd;
    for (int n = 0; n < 4; n++) begin
      if (bcd[4*n +: 4] >= 4'd5) begin
        bcd_adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM state register. Busy is registered from the next state,
  // so it is high exactly while the FSM sits in SHIFT or DONE.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      Busy  <= 1'b0;
    end else begin
      state <= state_next;
      Busy  <= (state_next != IDLE);
    end
  end

  // Conversion FSM next-state logic and datapath strobes.
  // A changed input is only looked at in IDLE. A value change during a
  // conversion is therefore picked up after the current result lands.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift_en   = 1'b0;
    write_disp = 1'b0;
    case (state)
      IDLE: begin
        if (vsat != last) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (count == 4'd1) begin
          state_next = DONE;
        end
      end
      DONE: begin
        write_disp = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Conversion datapath. disp is written only from DONE, as a single 16-bit
  // write, so the display never sees a half-converted number.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      last  <= '0;
      bin   <= '0;
      bcd   <= '0;
      count <= '0;
      disp  <= '0;
    end else begin
      if (load) begin
        last  <= vsat;
        bin   <= vsat;
        bcd   <= '0;
        count <= 4'd14;
      end
      if (shift_en) begin
        {bcd, bin} <= {bcd_adj, bin} << 1;
        count      <= count - 4'd1;
      end
      if (write_disp) begin
        disp <= bcd;
      end
    end
  end

  // Digit scan. The index advances once per divided-clock edge and wraps
  // from 3 to 0.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      clkin_q <= 1'b0;
      idx     <= 2'd0;
    end else begin
      clkin_q <= ClkIn;
      if (tick) begin
        idx <= idx + 2'd1;
      end
    end
  end

  // Select the digit being scanned. Also check whether that digit and every
  // digit above it are zero, which qualifies it for leading-zero blanking.
  always_comb begin
    digit      = disp[{idx, 2'b00} +: 4];
    upper_zero = 1'b0;
    case (idx)
      2'd3:    upper_zero = (disp[15:12] == 4'd0);
      2'd2:    upper_zero = (disp[15:8]  == 8'd0);
      2'd1:    upper_zero = (disp[15:4]  == 12'd0);
      default: upper_zero = (disp        == 16'd0);
    endcase
    blank = BLANK_LZ && (idx > BLANK_MIN) && upper_zero;
  end

  // Active-low gfedcba decode. BCD codes 10..15 never occur and show dark.
  always_comb begin
    seg_dec = 7'b1111111;
    case (digit)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = 7'b1111111;
    endcase
  end

  // Registered pin drivers. These follow idx/disp one cycle later.
  // A blanked digit still gets its anode driven, so scan timing stays even.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      An  <= 4'b1111;
      Seg <= 7'b1111111;
      Dp  <= 1'b1;
    end else begin
      An  <= ~(4'b0001 << idx);
      Seg <= blank ? 7'b1111111 : seg_dec;
      Dp  <= ({1'b0, idx} == DP_SEL) ? 1'b0 : 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// ---------------------------------------------------------------------------
// tb_seg_display_scan
//
// Directed bench for seg_display_scan with hand-computed expected values.
// It covers reset, conversion latency and the digit scan, saturation and
// leading-zero blanking, a value change mid-conversion, the divided-clock
// edge detector, and reset during a conversion.
// ---------------------------------------------------------------------------
module tb_seg_display_scan;

  logic        Clk;
  logic        Rst;
  logic        ClkIn;
  logic [13:0] Value;
  logic [6:0]  Seg;
  logic        Dp;
  logic [3:0]  An;
  logic        Busy;

  int tests_run  = 0;
  int fail_count = 0;

  seg_display_scan #(
    .BLANK_LZ (1'b1),
    .DP_POS   (2)
  ) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .ClkIn (ClkIn),
    .Value (Value),
    .Seg   (Seg),
    .Dp    (Dp),
    .An    (An),
    .Busy  (Busy)
  );

  // 100 MHz system clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Hard stop in case something hangs.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired before the directed sequence ended");
    $fatal(1, "[TB] watchdog");
  end

  // Advance one clock and settle just past the active edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [13:0] value, input logic clkin);
    Value = value;
    ClkIn = clkin;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkDigit(input string tag, input logic [3:0] an_exp,
                            input logic [6:0] seg_exp, input logic dp_exp);
    checkOutput({tag, "_an"},  {12'd0, An},  {12'd0, an_exp});
    checkOutput({tag, "_seg"}, {9'd0, Seg},  {9'd0, seg_exp});
    checkOutput({tag, "_dp"},  {15'd0, Dp},  {15'd0, dp_exp});
  endtask

  // One divided-clock rising edge. After this, the outputs show the new digit.
  task automatic pulseClkIn();
    ClkIn = 1'b1;
    step();
    ClkIn = 1'b0;
    step();
  endtask

  initial begin
    int          busy_cycles;
    int          changes;
    int          first_at;
    int          second_at;
    int          illegal;
    logic [15:0] prev_disp;
    logic [15:0] first_val;
    logic [15:0] second_val;

    // Reset
    Rst = 1'b1;
    applyStimulus(14'd0, 1'b0);
    repeat (3) step();
    checkDigit("reset", 4'b1111, 7'b1111111, 1'b1);
    checkOutput("reset_busy", {15'd0, Busy}, 16'd0);

    Rst = 1'b0;
    step();
    checkDigit("post_reset", 4'b1110, 7'b1000000, 1'b1);
    checkOutput("post_reset_busy", {15'd0, Busy}, 16'd0);

    // Conversion of 125: Busy high for 15 cycles, result at cycle 16
    applyStimulus(14'd125, 1'b0);
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (Busy) busy_cycles++;
      else if (busy_cycles != 0) break;
    end
    checkOutput("busy_len_125", 16'(busy_cycles), 16'd15);
    checkOutput("disp_125", dut.disp, 16'h0125);
    step();
    checkDigit("scan125_d0", 4'b1110, 7'b0010010, 1'b1);
    pulseClkIn();
    checkDigit("scan125_d1", 4'b1101, 7'b0100100, 1'b1);
    pulseClkIn();
    checkDigit("scan125_d2", 4'b1011, 7'b1111001, 1'b0);
    pulseClkIn();
    checkDigit("scan125_d3", 4'b0111, 7'b1111111, 1'b1);
    pulseClkIn();
    checkDigit("scan125_wrap", 4'b1110, 7'b0010010, 1'b1);

    // ClkIn held high: only one advance
    ClkIn = 1'b1;
    repeat (1000) step();
    checkOutput("hold_high_an", {12'd0, An}, 16'h000D);
    ClkIn = 1'b0;
    step();
    step();
    checkOutput("hold_low_an", {12'd0, An}, 16'h000D);

    // Saturation: 12000 shows as 9999 and no digit is blanked
    applyStimulus(14'd12000, 1'b0);
    repeat (20) step();
    checkOutput("disp_sat", dut.disp, 16'h9999);
    checkDigit("sat_d1", 4'b1101, 7'b0010000, 1'b1);
    pulseClkIn();
    checkDigit("sat_d2", 4'b1011, 7'b0010000, 1'b0);
    pulseClkIn();
    checkDigit("sat_d3", 4'b0111, 7'b0010000, 1'b1);
    pulseClkIn();
    checkDigit("sat_d0", 4'b1110, 7'b0010000, 1'b1);

    // Value 5: digit 3 blanked; digits 2 and 1 still show 0
    applyStimulus(14'd5, 1'b0);
    repeat (20) step();
    checkOutput("disp_5", dut.disp, 16'h0005);
    checkDigit("five_d0", 4'b1110, 7'b0010010, 1'b1);
    pulseClkIn();
    checkDigit("five_d1", 4'b1101, 7'b1000000, 1'b1);
    pulseClkIn();
    checkDigit("five_d2", 4'b1011, 7'b1000000, 1'b0);
    pulseClkIn();
    checkDigit("five_d3", 4'b0111, 7'b1111111, 1'b1);
    pulseClkIn();

    // Mid-conversion change: 125, then 340 five cycles later
    applyStimulus(14'd125, 1'b0);
    prev_disp  = dut.disp;
    changes    = 0;
    first_at   = 0;
    second_at  = 0;
    first_val  = '0;
    second_val = '0;
    illegal    = 0;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (c == 5) Value = 14'd340;
      if (dut.disp !== prev_disp) begin
        changes++;
        if (changes == 1) begin
          first_at  = c;
          first_val = dut.disp;
        end else if (changes == 2) begin
          second_at  = c;
          second_val = dut.disp;
        end
        if (dut.disp !== 16'h0125 && dut.disp !== 16'h0340) illegal++;
        prev_disp = dut.disp;
      end
    end
    checkOutput("mid_changes", 16'(changes), 16'd2);
    checkOutput("mid_first_at", 16'(first_at), 16'd16);
    checkOutput("mid_first_val", first_val, 16'h0125);
    checkOutput("mid_second_at", 16'(second_at), 16'd32);
    checkOutput("mid_second_val", second_val, 16'h0340);
    checkOutput("mid_illegal", 16'(illegal), 16'd0);

    // Reset during the seventh SHIFT cycle of a 9999 conversion
    applyStimulus(14'd9999, 1'b0);
    repeat (8) step();
    checkOutput("pre_abort_busy", {15'd0, Busy}, 16'd1);
    Rst = 1'b1;
    step();
    checkOutput("abort_busy", {15'd0, Busy}, 16'd0);
    checkOutput("abort_disp", dut.disp, 16'h0000);
    checkOutput("abort_an", {12'd0, An}, 16'h000F);
    Rst = 1'b0;
    repeat (15) step();
    checkOutput("restart_not_early", dut.disp, 16'h0000);
    step();
    checkOutput("restart_disp", dut.disp, 16'h9999);
    checkOutput("restart_busy", {15'd0, Busy}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
